// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. It sends one command byte to the keyboard by
// driving the shared ps2_clk/ps2_data lines open-drain.
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 2440,
  parameter int TIMEOUT_CYC = 366000,
  parameter int FILTER      = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_XFER,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] inh_cnt_reg, inh_cnt_next;
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic [3:0]    idx_reg, idx_next;
  logic [8:0]    shift_reg, shift_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          done_reg, done_next;
  logic          ack_err_reg, ack_err_next;
  logic          timeout_reg, timeout_next;
  logic          nack_reg, nack_next;

  logic [1:0]    clk_sync_reg, data_sync_reg;
  logic [FW-1:0] low_cnt_reg;
  logic          armed_reg;
  logic          fe_reg;
  logic          clk_s, data_s;
  logic          timeout_hit;

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

  // Synchronisers reset to 1 so an idle bus does not look like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk_i};
      data_sync_reg <= {data_sync_reg[0], ps2_data_i};
    end
  end

  // A falling edge counts only after FILTER consecutive lows that follow a high sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      low_cnt_reg <= '0;
      armed_reg   <= 1'b0;
      fe_reg      <= 1'b0;
    end else begin
      fe_reg <= 1'b0;
      if (clk_s) begin
        low_cnt_reg <= '0;
        armed_reg   <= 1'b1;
      end else if (armed_reg) begin
        if (low_cnt_reg == FW'(FILTER - 1)) begin
          fe_reg      <= 1'b1;
          armed_reg   <= 1'b0;
          low_cnt_reg <= '0;
        end else begin
          low_cnt_reg <= low_cnt_reg + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      inh_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      done_reg    <= 1'b0;
      ack_err_reg <= 1'b0;
      timeout_reg <= 1'b0;
      nack_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      inh_cnt_reg <= inh_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      done_reg    <= done_next;
      ack_err_reg <= ack_err_next;
      timeout_reg <= timeout_next;
      nack_reg    <= nack_next;
    end
  end

  assign timeout_hit = (state_reg inside {S_XFER, S_ACK, S_WAIT_IDLE}) &&
                       (to_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_next   = state_reg;
    inh_cnt_next = inh_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    idx_next     = idx_reg;
    shift_next   = shift_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    nack_next    = nack_reg;
    done_next    = 1'b0;
    ack_err_next = 1'b0;
    timeout_next = 1'b0;

    if (state_reg inside {S_XFER, S_ACK, S_WAIT_IDLE}) begin
      to_cnt_next = to_cnt_reg + TW'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (tx_valid) begin
          state_next   = S_INHIBIT;
          inh_cnt_next = '0;
          shift_next   = {~^tx_data, tx_data};
          clk_oe_next  = 1'b1;
        end
      end
      S_INHIBIT: begin
        inh_cnt_next = inh_cnt_reg + IW'(1);
        if (inh_cnt_reg == IW'(INHIBIT_CYC - 1)) begin
          state_next   = S_RTS;
          data_oe_next = 1'b1;
        end
      end
      S_RTS: begin
        state_next  = S_XFER;
        clk_oe_next = 1'b0;
        idx_next    = '0;
        to_cnt_next = '0;
      end
      S_XFER: begin
        if (fe_reg) begin
          if (idx_reg == 4'd9) begin
            data_oe_next = 1'b0;
            state_next   = S_ACK;
          end else begin
            // Shift out LSB first; the parity bit sits at the top of the register.
            data_oe_next = ~shift_reg[0];
            shift_next   = {1'b0, shift_reg[8:1]};
            idx_next     = idx_reg + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fe_reg) begin
          nack_next  = data_s;
          state_next = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          state_next   = S_IDLE;
          done_next    = 1'b1;
          ack_err_next = nack_reg;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Timeout overrides whatever the bus did this cycle.
    if (timeout_hit) begin
      state_next   = S_IDLE;
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      done_next    = 1'b1;
      ack_err_next = 1'b0;
      timeout_next = 1'b1;
    end
  end

  assign tx_ready    = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign done        = done_reg;
  assign ack_err     = ack_err_reg;
  assign timeout     = timeout_reg;
  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;

endmodule
